// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: index-width helper and
// the names of the two storage states (the state is q_valid itself).
package shared_reg_arbiter_pkg;

  // Ceiling log2 for deriving index widths from requester counts.
  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Storage state encodings; q_valid carries these values directly.
  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first eligible request at or
// after the priority pointer, wrapping from NREQ-1 back to 0.
module shared_reg_arbiter_rr_pick
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_int(NREQ)
) (
  input  logic [NREQ-1:0] req_m,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  winner,
  output logic [NREQ-1:0] onehot
);

  logic [IDW-1:0] idx;

  // Scan NREQ positions starting at ptr; the first set bit wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    any    = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req_m[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
      // NOTE: blocking assignment here because idx must update within this scan iteration.
      // Explicit wrap compare keeps non-power-of-two NREQ correct.
      idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
    end
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter loading one shared WIDTH-bit register, held as a
// one-deep buffer until the consumer acknowledges it.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = clog2_int(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  input  logic                  q_ack,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  q_valid,
  output logic [IDW-1:0]        q_owner
);

  logic [IDW-1:0]   ptr;
  logic [NREQ-1:0]  req_m;
  logic             any;
  logic [IDW-1:0]   winner;
  logic [NREQ-1:0]  win_onehot;
  logic [WIDTH-1:0] wsel;
  logic             load_en;

  // A requester still seeing its grant is masked so it cannot win twice.
  assign req_m   = req & ~gnt;
  assign load_en = any && (!q_valid || q_ack);

  shared_reg_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_m  (req_m),
    .ptr    (ptr),
    .any    (any),
    .winner (winner),
    .onehot (win_onehot)
  );

  // Select the winner's data slice from the packed write bus.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) wsel = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Storage register, handshake state, grant pulse and priority pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      q_valid <= ST_EMPTY;
      gnt     <= '0;
      q_owner <= '0;
      ptr     <= '0;
    end else if (load_en) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      q       <= wsel;
      q_valid <= ST_FULL;
      q_owner <= winner;
      gnt     <= win_onehot;
      ptr     <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
    end else begin
      gnt <= '0;
      if (q_valid && q_ack) q_valid <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter (NREQ=4, WIDTH=8): a vector table for
// the handshake paths plus hand sequences for reset and round-robin order.
module tb_shared_reg_arbiter;
  import shared_reg_arbiter_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  q_ack;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [1:0]            q_owner;

  int n_pass  = 0;
  int n_total = 0;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wdata   (wdata),
    .q_ack   (q_ack),
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_owner (q_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        ack;
    logic [7:0]  q;
    logic        valid;
    logic [3:0]  gnt;
    logic [1:0]  owner;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq, input logic ev,
                           input logic [3:0] eg, input logic [1:0] eo);
    check({tag, " q"},       32'(q),       32'(eq));
    check({tag, " q_valid"}, 32'(q_valid), 32'(ev));
    check({tag, " gnt"},     32'(gnt),     32'(eg));
    check({tag, " q_owner"}, 32'(q_owner), 32'(eo));
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [3:0] r, input logic [31:0] wd, input logic a);
    req   = r;
    wdata = wd;
    q_ack = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Vector table: single write, stall, pass-through, drain, masking, wrap.
    vecs[0]  = '{4'b0001, 32'h000000A5, 1'b0, 8'hA5, ST_FULL,  4'b0001, 2'd0};
    vecs[1]  = '{4'b0000, 32'h000000A5, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[2]  = '{4'b0010, 32'h00003C00, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[3]  = '{4'b0010, 32'h00003C00, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[4]  = '{4'b0010, 32'h00003C00, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[5]  = '{4'b0010, 32'h00003C00, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[6]  = '{4'b0010, 32'h00003C00, 1'b0, 8'hA5, ST_FULL,  4'b0000, 2'd0};
    vecs[7]  = '{4'b0010, 32'h00003C00, 1'b1, 8'h3C, ST_FULL,  4'b0010, 2'd1};
    vecs[8]  = '{4'b0000, 32'h00000000, 1'b1, 8'h3C, ST_EMPTY, 4'b0000, 2'd1};
    vecs[9]  = '{4'b0000, 32'h00000000, 1'b1, 8'h3C, ST_EMPTY, 4'b0000, 2'd1};
    vecs[10] = '{4'b0100, 32'h005A0000, 1'b0, 8'h5A, ST_FULL,  4'b0100, 2'd2};
    vecs[11] = '{4'b0100, 32'h005A0000, 1'b1, 8'h5A, ST_EMPTY, 4'b0000, 2'd2};
    vecs[12] = '{4'b1001, 32'h99000011, 1'b0, 8'h99, ST_FULL,  4'b1000, 2'd3};
    vecs[13] = '{4'b0001, 32'h00000011, 1'b1, 8'h11, ST_FULL,  4'b0001, 2'd0};
    vecs[14] = '{4'b0000, 32'h00000000, 1'b0, 8'h11, ST_FULL,  4'b0000, 2'd0};

    // Reset asserted between edges with random inputs: clears immediately.
    req   = 4'($urandom);
    wdata = $urandom;
    q_ack = 1'($urandom);
    #2;
    reset = 1'b0;
    #1;
    check_all("reset_async", 8'h00, ST_EMPTY, 4'b0000, 2'd0);
    for (int i = 0; i < 3; i++) begin
      req   = 4'($urandom) | 4'b0001;
      wdata = $urandom;
      q_ack = 1'($urandom);
      @(posedge clk);
      #1;
      check_all($sformatf("reset_hold%0d", i), 8'h00, ST_EMPTY, 4'b0000, 2'd0);
    end
    req   = '0;
    q_ack = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].req, vecs[i].wdata, vecs[i].ack);
      check_all($sformatf("v%0d", i), vecs[i].q, vecs[i].valid, vecs[i].gnt, vecs[i].owner);
    end

    // Round robin after a fresh reset with all requesters held.
    #2;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr0", 8'h11, ST_FULL, 4'b0001, 2'd0);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr1", 8'h22, ST_FULL, 4'b0010, 2'd1);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr2", 8'h33, ST_FULL, 4'b0100, 2'd2);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr3", 8'h44, ST_FULL, 4'b1000, 2'd3);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr4", 8'h11, ST_FULL, 4'b0001, 2'd0);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("rr5", 8'h22, ST_FULL, 4'b0010, 2'd1);

    // Reset pulled mid-cycle during the burst: clears before the next edge,
    // and the pointer restarts at requester 0.
    #2;
    reset = 1'b0;
    #1;
    check_all("midrst", 8'h00, ST_EMPTY, 4'b0000, 2'd0);
    #1;
    reset = 1'b1;
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("post_rst0", 8'h11, ST_FULL, 4'b0001, 2'd0);
    step(4'b1111, 32'h44332211, 1'b1);
    check_all("post_rst1", 8'h22, ST_FULL, 4'b0010, 2'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
